// File: rtl/xup_demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Lane count, lane-select width and routing-mode encodings.
package xup_demux_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_SEL_W = 2;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/xup_demux_lane_fifo.sv
// Per-lane FIFO with extended-pointer full/empty detection.
// The head output holds the last head value once the lane drains.
module xup_demux_lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign valid   = ~empty;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            last_q <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
            if (!empty)
                last_q <= mem[rptr[AW-1:0]];
        end
    end

    // Storage needs no reset: it is only observed while the lane is non-empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= din;
    end

    assign dout = empty ? last_q : mem[rptr[AW-1:0]];

endmodule

// File: rtl/xup_1_to_4_stream_demux.sv
// One input stream fanned out to four independently buffered lanes.
// Routing is by in_dest (addressed) or by an internal round-robin pointer.
module xup_1_to_4_stream_demux
    import xup_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [LANE_SEL_W-1:0]  in_dest,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*WIDTH-1:0]     out_data,
    output logic [NUM_LANES-1:0]   out_valid,
    input  logic [NUM_LANES-1:0]   out_ready,
    output logic [LANE_SEL_W-1:0]  rr_ptr,
    output logic                   busy
);

    localparam logic [LANE_SEL_W-1:0] RR_ONE = 1;

    logic [LANE_SEL_W-1:0] target;
    logic [NUM_LANES-1:0]  full;
    logic [NUM_LANES-1:0]  push;
    logic                  accept;

    assign target   = (mode == MODE_ADDR) ? in_dest : rr_ptr;
    assign in_ready = ~full[target];
    assign accept   = in_valid & in_ready;
    assign busy     = |out_valid;

    always_comb begin
        push         = '0;
        push[target] = accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (accept && (mode == MODE_RR))
            rr_ptr <= rr_ptr + RR_ONE;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        xup_demux_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .din   (in_data),
            .full  (full[i]),
            .pop   (out_ready[i]),
            .dout  (out_data[i*WIDTH +: WIDTH]),
            .valid (out_valid[i])
        );
    end

endmodule

// File: tb/tb_xup_1_to_4_stream_demux.sv
// Directed self-checking bench for the 1-to-4 stream demultiplexer.
module tb_xup_1_to_4_stream_demux;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [7:0]  in_data;
    logic [1:0]  in_dest;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;
    logic        busy;

    int checks;
    int failures;

    xup_1_to_4_stream_demux #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lane(input int n);
        return out_data[n*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        mode      = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mode      = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        in_dest   = 2'd0;
        out_ready = 4'b0000;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000);
        end
        checks++;
        if (rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL reset_rrptr got=%0d exp=0", rr_ptr);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", out_data);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000 || rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL reset_nostore got=%b/%0d exp=0000/0",
                     out_valid, rr_ptr);
        end
    endtask

    task automatic test_addressed();
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply_reset();
        mode      = 1'b0;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_data  = words[i];
            in_dest  = 2'(i);
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 4'(1 << i) || lane(i) !== words[i]) begin
                failures++;
                $display("FAIL addr_lane%0d got=%b/%h exp=%b/%h",
                         i, out_valid, lane(i), 4'(1 << i), words[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL addr_drain got=%b/%b/%0d exp=0000/0/0",
                     out_valid, busy, rr_ptr);
        end
        checks++;
        if (lane(3) !== 8'h44) begin
            failures++;
            $display("FAIL addr_hold got=%h exp=44", lane(3));
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        mode      = 1'b1;
        out_ready = 4'b1111;
        in_dest   = 2'd3;
        for (int i = 0; i < 8; i++) begin
            in_data  = 8'hA0 + 8'(i);
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 4'(1 << (i % 4)) ||
                lane(i % 4) !== 8'hA0 + 8'(i) ||
                rr_ptr !== 2'((i + 1) % 4)) begin
                failures++;
                $display("FAIL rr_word%0d got=%b/%h/%0d exp=%b/%h/%0d",
                         i, out_valid, lane(i % 4), rr_ptr,
                         4'(1 << (i % 4)), 8'hA0 + 8'(i), (i + 1) % 4);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (rr_ptr !== 2'd0 || out_valid !== 4'b0000) begin
            failures++;
            $display("FAIL rr_idle got=%0d/%b exp=0/0000", rr_ptr, out_valid);
        end
    endtask

    task automatic test_full();
        apply_reset();
        mode      = 1'b0;
        in_dest   = 2'd2;
        out_ready = 4'b1011;
        in_data   = 8'h01;
        in_valid  = 1'b1;
        step();
        in_data = 8'h02;
        step();
        in_data = 8'h03;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%b exp=0", in_ready);
        end
        step();
        checks++;
        if (out_valid[2] !== 1'b1 || lane(2) !== 8'h01) begin
            failures++;
            $display("FAIL full_head got=%b/%h exp=1/01", out_valid[2], lane(2));
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_popblock got=%b exp=0", in_ready);
        end
        step();
        checks++;
        if (lane(2) !== 8'h02 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop1 got=%h/%b exp=02/1", lane(2), in_ready);
        end
        step();
        checks++;
        if (out_valid[2] !== 1'b1 || lane(2) !== 8'h03) begin
            failures++;
            $display("FAIL full_third got=%b/%h exp=1/03", out_valid[2], lane(2));
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_drain got=%b/%b exp=0000/0", out_valid, busy);
        end
    endtask

    task automatic test_independence();
        apply_reset();
        mode      = 1'b0;
        out_ready = 4'b1101;
        in_dest   = 2'd1;
        in_valid  = 1'b1;
        in_data   = 8'h61;
        step();
        in_data = 8'h62;
        step();
        in_dest = 2'd0;
        in_data = 8'h70;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL indep_ready got=%b exp=1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 4'b0011 || lane(0) !== 8'h70 || lane(1) !== 8'h61) begin
            failures++;
            $display("FAIL indep_deliver got=%b/%h/%h exp=0011/70/61",
                     out_valid, lane(0), lane(1));
        end
        in_dest = 2'd1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL indep_stalled got=%b exp=0", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode      = 1'b0;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_dest   = 2'd0;
        in_data   = 8'h10;
        step();
        in_dest = 2'd3;
        in_data = 8'h30;
        step();
        mode    = 1'b1;
        in_data = 8'hC0;
        step();
        in_data = 8'hC1;
        step();
        in_valid = 1'b0;
        checks++;
        if (rr_ptr !== 2'd2 || out_valid !== 4'b1011) begin
            failures++;
            $display("FAIL mid_setup got=%0d/%b exp=2/1011", rr_ptr, out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || rr_ptr !== 2'd0 ||
            busy !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_async got=%b/%0d/%b/%h exp=0000/0/0/0",
                     out_valid, rr_ptr, busy, out_data);
        end
        #2;
        reset = 1'b0;
        step();
        mode      = 1'b1;
        out_ready = 4'b1111;
        in_data   = 8'h5A;
        in_dest   = 2'd2;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0001 || lane(0) !== 8'h5A || rr_ptr !== 2'd1) begin
            failures++;
            $display("FAIL mid_after got=%b/%h/%0d exp=0001/5a/1",
                     out_valid, lane(0), rr_ptr);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        mode      = 1'b0;
        out_ready = 4'b0000;
        in_dest   = 2'd0;
        in_data   = 8'hAA;
        in_valid  = 1'b1;
        step();
        in_data   = 8'hBB;
        out_ready = 4'b0001;
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (out_valid[0] !== 1'b1 || lane(0) !== 8'hBB) begin
            failures++;
            $display("FAIL simul_head got=%b/%h exp=1/bb", out_valid[0], lane(0));
        end
        out_ready = 4'b0001;
        step();
        checks++;
        if (out_valid[0] !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_occ got=%b/%b exp=0/0", out_valid[0], busy);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        mode      = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        #1;
        test_reset();
        test_addressed();
        test_round_robin();
        test_full();
        test_independence();
        test_reset_mid();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
